// File: rtl/batch_stream_host.sv
// batch_stream_host: host-side end of the accelerator batch stream.
// Reads source frames from a 1-cycle-latency buffer port through a 2-entry
// output FIFO onto the src_* stream, and writes dst_* result words to the
// result buffer. Optional stall counters are built when STREAM_STATS_EN is
// defined.
module batch_stream_host #(
    parameter int DW = 32,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    nframe,
    input  logic [11:0]   ss,
    input  logic [11:0]   ds,
    input  logic          dst_pause,
    output logic          busy,
    output logic          done,
    output logic          mrd_en,
    output logic [AW-1:0] mrd_addr,
    input  logic [DW-1:0] mrd_data,
    output logic          src_valid,
    output logic [DW-1:0] src_data,
    output logic          src_last,
    input  logic          src_ready,
    input  logic          dst_valid,
    input  logic [DW-1:0] dst_data,
    output logic          dst_ready,
    output logic          mwr_en,
    output logic [AW-1:0] mwr_addr,
    output logic [DW-1:0] mwr_data
`ifdef STREAM_STATS_EN
    ,
    output logic [15:0]   src_stall,
    output logic [15:0]   dst_stall
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t state_q, state_d;

    // Job geometry captured at start
    logic [7:0]    nframe_q;
    logic [11:0]   ss_q;
    logic [11:0]   ds_q;

    // Source read side
    logic [11:0]   rd_word_q;
    logic [7:0]    rd_frame_q;
    logic          rd_done_q;
    logic [AW-1:0] mrd_addr_q;
    logic          infl_q;
    logic          infl_last_q;

    // Output FIFO, entry 0 is the head
    logic [DW-1:0] f0_data_q, f0_data_d, f1_data_q, f1_data_d;
    logic          f0_last_q, f0_last_d, f1_last_q, f1_last_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [7:0]    tx_frame_q;

    // Result write side
    logic [11:0]   rx_word_q;
    logic [7:0]    rx_frame_q;
    logic          rx_done_q;
    logic [AW-1:0] mwr_addr_q;

    logic          start_ok;
    logic          rx_win;
    logic          push;
    logic          pop;
    logic [1:0]    occ_after;
    logic          tx_final;
    logic          rx_acc;
    logic          rx_final;

    assign start_ok  = (state_q == IDLE) && start;
    assign rx_win    = (state_q == RUN) || (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

    assign src_valid = (cnt_q != 2'd0);
    assign src_data  = f0_data_q;
    assign src_last  = f0_last_q && src_valid;
    assign pop       = src_valid && src_ready;
    assign push      = infl_q;

    // Occupancy is judged after this cycle's pop so a read can be issued
    // every cycle while the sink keeps accepting.
    assign occ_after = cnt_q - {1'b0, pop};
    assign mrd_en    = (state_q == RUN) && !rd_done_q &&
                       ((occ_after + {1'b0, infl_q}) < 2'd2);
    assign mrd_addr  = mrd_addr_q;

    assign tx_final  = pop && src_last && (tx_frame_q == nframe_q);

    assign dst_ready = rx_win && !rx_done_q && !dst_pause;
    assign rx_acc    = dst_valid && dst_ready;
    assign rx_final  = rx_acc && (rx_word_q == ds_q) && (rx_frame_q == nframe_q);
    assign mwr_en    = rx_acc;
    assign mwr_addr  = mwr_addr_q;
    assign mwr_data  = dst_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: FIN follows whichever direction finishes last
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (tx_final) state_d = (rx_done_q || rx_final) ? FIN : DRAIN;
            DRAIN:   if (rx_final) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch job geometry on an accepted start
    always_ff @(posedge clk) begin
        if (start_ok) begin
            nframe_q <= nframe;
            ss_q     <= ss;
            ds_q     <= ds;
        end
    end

    // Source read address and frame/word position of the next read
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            rd_word_q  <= '0;
            rd_frame_q <= '0;
            rd_done_q  <= 1'b0;
            mrd_addr_q <= '0;
        end else if (mrd_en) begin
            mrd_addr_q <= mrd_addr_q + 1'b1;
            if (rd_word_q == ss_q) begin
                rd_word_q  <= '0;
                rd_frame_q <= rd_frame_q + 8'd1;
                if (rd_frame_q == nframe_q) rd_done_q <= 1'b1;
            end else begin
                rd_word_q <= rd_word_q + 12'd1;
            end
        end
    end

    // In-flight read marker; the word returns on mrd_data next cycle
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q      <= mrd_en;
            infl_last_q <= mrd_en && (rd_word_q == ss_q);
        end
    end

    // FIFO next state: shift on pop, fill the first free slot on push
    always_comb begin
        f0_data_d = f0_data_q;
        f0_last_d = f0_last_q;
        f1_data_d = f1_data_q;
        f1_last_d = f1_last_q;
        cnt_d     = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    f0_data_d = mrd_data;
                    f0_last_d = infl_last_q;
                end else begin
                    f1_data_d = mrd_data;
                    f1_last_d = infl_last_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                f0_data_d = f1_data_q;
                f0_last_d = f1_last_q;
                cnt_d     = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    f0_data_d = mrd_data;
                    f0_last_d = infl_last_q;
                end else begin
                    f0_data_d = f1_data_q;
                    f0_last_d = f1_last_q;
                    f1_data_d = mrd_data;
                    f1_last_d = infl_last_q;
                end
            end
            default: ;
        endcase
    end

    // FIFO storage; reset also clears the head so src_data reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            f0_data_q <= '0;
            f0_last_q <= 1'b0;
            f1_data_q <= '0;
            f1_last_q <= 1'b0;
            cnt_q     <= 2'd0;
        end else if (start_ok) begin
            cnt_q     <= 2'd0;
        end else begin
            f0_data_q <= f0_data_d;
            f0_last_q <= f0_last_d;
            f1_data_q <= f1_data_d;
            f1_last_q <= f1_last_d;
            cnt_q     <= cnt_d;
        end
    end

    // Count frames leaving on the stream to spot the final source word
    always_ff @(posedge clk) begin
        if (rst || start_ok)      tx_frame_q <= '0;
        else if (pop && src_last) tx_frame_q <= tx_frame_q + 8'd1;
    end

    // Result write address and frame/word position
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            rx_word_q  <= '0;
            rx_frame_q <= '0;
            rx_done_q  <= 1'b0;
            mwr_addr_q <= '0;
        end else if (rx_acc) begin
            mwr_addr_q <= mwr_addr_q + 1'b1;
            if (rx_word_q == ds_q) begin
                rx_word_q  <= '0;
                rx_frame_q <= rx_frame_q + 8'd1;
                if (rx_frame_q == nframe_q) rx_done_q <= 1'b1;
            end else begin
                rx_word_q <= rx_word_q + 12'd1;
            end
        end
    end

`ifdef STREAM_STATS_EN
    logic [15:0] src_stall_q;
    logic [15:0] dst_stall_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating stall counters, cleared when a job starts
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            src_stall_q <= '0;
            dst_stall_q <= '0;
        end else begin
            if (src_valid && !src_ready) src_stall_q <= sat_inc(src_stall_q);
            if (rx_win && !rx_done_q && !rx_acc) dst_stall_q <= sat_inc(dst_stall_q);
        end
    end

    assign src_stall = src_stall_q;
    assign dst_stall = dst_stall_q;
`endif

endmodule

// File: tb/tb_batch_stream_host.sv
// Testbench for batch_stream_host: scoreboard of expected source words and
// result writes, scenario tasks run in sequence. Stall counters are checked
// when STREAM_STATS_EN is defined.
module tb_batch_stream_host;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    nframe = '0;
    logic [11:0]   ss = '0;
    logic [11:0]   ds = '0;
    logic          dst_pause = 1'b0;
    logic          busy, done, mrd_en;
    logic [AW-1:0] mrd_addr;
    logic [DW-1:0] mrd_data = '0;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_last;
    logic          src_ready = 1'b0;
    logic          dst_valid = 1'b0;
    logic [DW-1:0] dst_data = '0;
    logic          dst_ready, mwr_en;
    logic [AW-1:0] mwr_addr;
    logic [DW-1:0] mwr_data;
`ifdef STREAM_STATS_EN
    logic [15:0]   src_stall, dst_stall;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW:0]      src_exp[$];
    logic [AW+DW-1:0] dst_exp[$];

    always #5 clk = ~clk;

    batch_stream_host #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .nframe(nframe), .ss(ss), .ds(ds),
        .dst_pause(dst_pause), .busy(busy), .done(done), .mrd_en(mrd_en),
        .mrd_addr(mrd_addr), .mrd_data(mrd_data), .src_valid(src_valid),
        .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
        .mwr_en(mwr_en), .mwr_addr(mwr_addr), .mwr_data(mwr_data)
`ifdef STREAM_STATS_EN
        , .src_stall(src_stall), .dst_stall(dst_stall)
`endif
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // Source buffer: one-cycle read latency
    always @(posedge clk) if (mrd_en) mrd_data <= mem_word(mrd_addr);

    // Generic job driver: fills the scoreboard, then plays the job cycle by cycle.
    // rdy_mode 0: always ready, 1: random, 2: stall stall_len valid cycles first.
    // dvld_mode 0: always valid, 1: random, 2: only once all source words left.
    task automatic run_job(input string name, input int nf, input int sw, input int dw,
                           input int rdy_mode, input int stall_len, input int dvld_mode,
                           input int p_start, input int p_len, input int budget);
        int c, n_rd, first_vld, vld_cycles, last_acc, last_src, n_done, stall_cnt, total_src, a;
        logic prev_stall, prev_last, seen_done, dvld, exp_rdy, acc;
        logic [DW-1:0] prev_data;
        logic [DW:0] sexp;
        logic [AW+DW-1:0] dexp;
        src_exp.delete();
        dst_exp.delete();
        a = 0;
        for (int f = 0; f <= nf; f++)
            for (int w = 0; w <= sw; w++) begin
                src_exp.push_back({(w == sw), mem_word(AW'(a))});
                a++;
            end
        total_src = a;
        for (int i = 0; i < (nf + 1) * (dw + 1); i++)
            dst_exp.push_back({AW'(i), 32'hD00D0000 ^ 32'(i)});
        n_rd = 0; first_vld = -1; vld_cycles = 0; last_acc = -10; last_src = -10;
        n_done = 0; stall_cnt = 0; prev_stall = 1'b0; prev_last = 1'b0;
        prev_data = '0; seen_done = 1'b0;

        @(negedge clk);
        start = 1'b1; nframe = 8'(nf); ss = 12'(sw); ds = 12'(dw);
        src_ready = 1'b1; dst_valid = 1'b0; dst_pause = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL %s idle_before_start busy=%b exp=0", name, busy);
        end
        c = 1;
        while (!seen_done && c < budget) begin
            @(negedge clk);
            start = (c == 5);      // must be ignored while busy
            nframe = 8'hFF; ss = 12'hFFF; ds = 12'hFFF;
            case (rdy_mode)
                0: src_ready = 1'b1;
                1: src_ready = 1'($urandom_range(0, 1));
                default: src_ready = !(src_valid && stall_cnt < stall_len);
            endcase
            if (rdy_mode == 2 && src_valid && !src_ready) stall_cnt++;
            dst_pause = (c >= p_start) && (c < p_start + p_len);
            case (dvld_mode)
                0: dvld = 1'b1;
                1: dvld = 1'($urandom_range(0, 1));
                default: dvld = (src_exp.size() == 0);
            endcase
            dst_valid = dvld && (dst_exp.size() > 0);
            dst_data = (dst_exp.size() > 0) ? dst_exp[0][DW-1:0] : '0;
            #1;
            if (prev_stall) begin
                tests_run++;
                if (src_valid !== 1'b1 || src_data !== prev_data || src_last !== prev_last) begin
                    tests_failed++;
                    $display("FAIL %s src_stable c=%0d got=%b/%h/%b exp=1/%h/%b", name, c,
                             src_valid, src_data, src_last, prev_data, prev_last);
                end
            end
            prev_stall = src_valid && !src_ready;
            prev_data = src_data;
            prev_last = src_last;
            if (mrd_en === 1'b1) begin
                tests_run++;
                if (mrd_addr !== AW'(n_rd)) begin
                    tests_failed++; $display("FAIL %s mrd_addr got=%0d exp=%0d", name, mrd_addr, n_rd);
                end
                n_rd++;
            end
            if (src_valid === 1'b1) begin
                if (first_vld < 0) first_vld = c;
                vld_cycles++;
            end
            if (src_valid === 1'b1 && src_ready) begin
                tests_run++;
                if (src_exp.size() == 0) begin
                    tests_failed++; $display("FAIL %s src_extra got=%h exp=none", name, src_data);
                end else begin
                    sexp = src_exp.pop_front();
                    if ({src_last, src_data} !== sexp) begin
                        tests_failed++;
                        $display("FAIL %s src_word got=%h exp=%h", name, {src_last, src_data}, sexp);
                    end
                end
                last_acc = c; last_src = c;
            end
            exp_rdy = !dst_pause && (dst_exp.size() > 0);
            tests_run++;
            if (dst_ready !== exp_rdy) begin
                tests_failed++; $display("FAIL %s dst_ready c=%0d got=%b exp=%b", name, c, dst_ready, exp_rdy);
            end
            acc = dst_valid && dst_ready;
            tests_run++;
            if (mwr_en !== acc) begin
                tests_failed++; $display("FAIL %s mwr_en c=%0d got=%b exp=%b", name, c, mwr_en, acc);
            end
            if (acc && dst_exp.size() > 0) begin
                dexp = dst_exp.pop_front();
                tests_run++;
                if ({mwr_addr, mwr_data} !== dexp) begin
                    tests_failed++;
                    $display("FAIL %s write got=%h exp=%h", name, {mwr_addr, mwr_data}, dexp);
                end
                last_acc = c;
            end
            if (done === 1'b1) begin
                n_done++;
                seen_done = 1'b1;
                tests_run++;
                if (c != last_acc + 1 || src_exp.size() != 0 || dst_exp.size() != 0 || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s done_timing c=%0d got last_acc=%0d src_left=%0d dst_left=%0d busy=%b exp c=last_acc+1, 0 left, busy=1",
                             name, c, last_acc, src_exp.size(), dst_exp.size(), busy);
                end
            end
            c++;
        end
        tests_run++;
        if (!seen_done) begin
            tests_failed++; $display("FAIL %s timeout got done=0 exp done within %0d cycles", name, budget);
        end
        @(negedge clk);
        start = 1'b0; src_ready = 1'b1; dst_valid = 1'b1; dst_pause = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, dst_ready, mwr_en, mrd_en} !== 5'b0) begin
            tests_failed++;
            $display("FAIL %s after_done got busy/done/dst_ready/mwr_en/mrd_en=%b exp=00000", name,
                     {busy, done, dst_ready, mwr_en, mrd_en});
        end
        tests_run++;
        if (n_rd != total_src || n_done != 1) begin
            tests_failed++; $display("FAIL %s counts got reads=%0d dones=%0d exp reads=%0d dones=1",
                                     name, n_rd, n_done, total_src);
        end
        if (rdy_mode == 0) begin
            tests_run++;
            if (first_vld != 3 || vld_cycles != total_src || last_src - first_vld + 1 != total_src) begin
                tests_failed++;
                $display("FAIL %s throughput got first=%0d vld=%0d span=%0d exp first=3 vld=span=%0d",
                         name, first_vld, vld_cycles, last_src - first_vld + 1, total_src);
            end
        end
        dst_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dst_valid = 1'b1; src_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({busy, done, mrd_en, src_valid, src_last, dst_ready, mwr_en} !== 7'b0) begin
            tests_failed++; $display("FAIL reset_ctrl got=%b exp=0000000",
                                     {busy, done, mrd_en, src_valid, src_last, dst_ready, mwr_en});
        end
        tests_run++;
        if (mrd_addr !== '0 || mwr_addr !== '0 || src_data !== '0) begin
            tests_failed++; $display("FAIL reset_data got mrd_addr=%h mwr_addr=%h src_data=%h exp=0",
                                     mrd_addr, mwr_addr, src_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (dst_ready !== 1'b0 || mwr_en !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL idle_dst_ignored got dst_ready=%b mwr_en=%b busy=%b exp=0",
                                     dst_ready, mwr_en, busy);
        end
        dst_valid = 1'b0;
    endtask

    task automatic test_single_frame();
        run_job("single", 0, 3, 1, 0, 0, 1, 0, 0, 300);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 2, 7, 2, 1, 0, 1, 0, 0, 1000);
    endtask

    task automatic test_full_throughput();
        run_job("throughput", 3, 15, 3, 0, 0, 0, 0, 0, 500);
    endtask

    task automatic test_rx_pause();
        run_job("rx_pause", 1, 1, 4, 0, 0, 0, 3, 5, 300);
    endtask

    task automatic test_reset_midjob();
        int n, c;
        @(negedge clk);
        start = 1'b1; nframe = 8'd1; ss = 12'd7; ds = 12'd3;
        src_ready = 1'b1; dst_valid = 1'b0; dst_pause = 1'b0;
        n = 0; c = 0;
        while (n < 5 && c < 50) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (src_valid === 1'b1 && src_ready) begin
                tests_run++;
                if (src_data !== mem_word(AW'(n)) || src_last !== 1'b0) begin
                    tests_failed++; $display("FAIL midjob_word got=%h/%b exp=%h/0",
                                             src_data, src_last, mem_word(AW'(n)));
                end
                n++;
            end
            c++;
        end
        tests_run++;
        if (n < 5) begin
            tests_failed++; $display("FAIL midjob_timeout got words=%0d exp=5", n);
        end
        @(negedge clk);
        rst = 1'b1; dst_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, mrd_en, src_valid, src_last, dst_ready, mwr_en} !== 7'b0) begin
            tests_failed++; $display("FAIL midjob_reset_ctrl got=%b exp=0000000",
                                     {busy, done, mrd_en, src_valid, src_last, dst_ready, mwr_en});
        end
        tests_run++;
        if (mrd_addr !== '0 || mwr_addr !== '0 || src_data !== '0) begin
            tests_failed++; $display("FAIL midjob_reset_data got mrd_addr=%h mwr_addr=%h src_data=%h exp=0",
                                     mrd_addr, mwr_addr, src_data);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL midjob_no_done got done=%b busy=%b exp=0", done, busy);
            end
        end
        dst_valid = 1'b0;
        run_job("restart", 0, 2, 0, 0, 0, 0, 0, 0, 200);
    endtask

`ifdef STREAM_STATS_EN
    task automatic test_stats();
        run_job("stats", 0, 3, 1, 2, 6, 0, 0, 0, 300);
        tests_run++;
        if (src_stall !== 16'd6 || dst_stall !== 16'd0) begin
            tests_failed++; $display("FAIL stats_count got src=%0d dst=%0d exp src=6 dst=0", src_stall, dst_stall);
        end
        run_job("stats_sat", 0, 3, 1, 2, 70000, 2, 0, 0, 72000);
        tests_run++;
        if (src_stall !== 16'hFFFF || dst_stall !== 16'hFFFF) begin
            tests_failed++; $display("FAIL stats_sat got src=%0d dst=%0d exp 65535", src_stall, dst_stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_full_throughput();
        test_rx_pause();
        test_reset_midjob();
`ifdef STREAM_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
